// File: rtl/shift_pkg.sv
// Shared types and the single-step datapath function for univ_shift_reg.
//
// Contents:
//   MaxWidth  - widest register the step function handles (64 bits)
//   op_e      - operation codes (HOLD..CLEAR)
//   state_e   - auto-sequencer states (IDLE, SHIFT, DONE)
//   step_t    - {ser_out, value} result of one step
//   next_val  - executes one op on a register of run-time width `width`
package shift_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef enum logic [2:0] {
        OpHold  = 3'd0,
        OpLoad  = 3'd1,
        OpShl   = 3'd2,
        OpShr   = 3'd3,
        OpRol   = 3'd4,
        OpRor   = 3'd5,
        OpAsr   = 3'd6,
        OpClear = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    typedef struct packed {
        logic                ser_out;
        logic [MaxWidth-1:0] val;
    } step_t;

    // One step of `op` on `cur`, which holds a `width`-bit value zero-extended to MaxWidth.
    // The result value is also zero above `width`. ser_out keeps `cur_ser` on non-shift ops.
    function automatic step_t next_val(
        input op_e                 op,
        input logic [MaxWidth-1:0] cur,
        input logic                ser_in,
        input logic                cur_ser,
        input logic [MaxWidth-1:0] load_val,
        input int unsigned         width
    );
        logic [MaxWidth-1:0] mask;
        logic [MaxWidth-1:0] msb_shifted;
        logic                msb;
        logic                lsb;
        step_t               res;

        // (1 << 64) wraps to 0, so the subtraction yields all ones at full width.
        mask        = (MaxWidth'(1) << width) - MaxWidth'(1);
        msb_shifted = cur >> (width - 1);
        msb         = msb_shifted[0];
        lsb         = cur[0];

        res.ser_out = cur_ser;
        res.val     = cur;
        unique case (op)
            OpHold: ;
            OpLoad: res.val = load_val & mask;
            OpShl: begin
                res.val     = ((cur << 1) | MaxWidth'(ser_in)) & mask;
                res.ser_out = msb;
            end
            OpShr: begin
                res.val     = (cur >> 1) | (MaxWidth'(ser_in) << (width - 1));
                res.ser_out = lsb;
            end
            OpRol: begin
                res.val     = ((cur << 1) | MaxWidth'(msb)) & mask;
                res.ser_out = msb;
            end
            OpRor: begin
                res.val     = (cur >> 1) | (MaxWidth'(lsb) << (width - 1));
                res.ser_out = lsb;
            end
            OpAsr: begin
                res.val     = (cur >> 1) | (MaxWidth'(msb) << (width - 1));
                res.ser_out = lsb;
            end
            OpClear: res.val = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with an auto-sequencer.
//
// Direct mode executes `op` on every clock edge while idle. Asserting `start` while idle latches
// op/shift_cnt/parallel_in and repeats the op shift_cnt times, then pulses `done` for one cycle.
//
// Ports:
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   op           - operation code (shift_pkg::op_e)
//   start        - launch auto-sequence of op, shift_cnt times
//   shift_cnt    - number of auto-sequence steps
//   parallel_in  - data for LOAD
//   ser_in       - bit inserted on SHL/SHR, sampled live every step
//   parallel_out - register contents
//   ser_out      - last bit shifted/rotated out
//   busy         - auto-sequence in progress
//   done         - one-cycle pulse when the auto-sequence completes
//
// WIDTH must lie in 2..shift_pkg::MaxWidth.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic [CW-1:0]    shift_cnt,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             ser_q, ser_d;

    op_e              exec_op;
    logic [WIDTH-1:0] exec_ld;
    step_t            step;
    logic             unused_step;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        ld_d    = ld_q;
        exec_op = OpHold;
        exec_ld = parallel_in;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // The register is left untouched on the accepting edge.
                    op_d = op_e'(op);
                    ld_d = parallel_in;
                    if (shift_cnt == '0 || op_e'(op) == OpHold) begin
                        rem_d   = '0;
                        state_d = StDone;
                    end else begin
                        rem_d   = shift_cnt;
                        state_d = StShift;
                    end
                end else begin
                    exec_op = op_e'(op);
                end
            end
            StShift: begin
                exec_op = op_q;
                exec_ld = ld_q;
                rem_d   = rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        step  = next_val(exec_op, MaxWidth'(reg_q), ser_in, ser_q, MaxWidth'(exec_ld), WIDTH);
        reg_d = step.val[WIDTH-1:0];
        ser_d = step.ser_out;
    end

    // Bits above WIDTH are always zero.
    assign unused_step = ^step.val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpHold;
            rem_q   <= '0;
            ld_q    <= '0;
            reg_q   <= '0;
            ser_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            ld_q    <= ld_d;
            reg_q   <= reg_d;
            ser_q   <= ser_d;
        end
    end

    assign parallel_out = reg_q;
    assign ser_out      = ser_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: three instances (WIDTH 8, 2, 32) share one stimulus stream and are
// compared every cycle against an arithmetic reference model, plus directed value checks.
module tb_univ_shift_reg;

    logic        clk;
    logic        rst_n;
    logic [2:0]  op;
    logic        start;
    logic [5:0]  cnt;
    logic [31:0] pin;
    logic        ser_in;

    logic [7:0]  pout8;
    logic [1:0]  pout2;
    logic [31:0] pout32;
    logic [2:0]  so;
    logic [2:0]  bsy;
    logic [2:0]  dn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .op(op), .start(start), .shift_cnt(cnt[3:0]),
        .parallel_in(pin[7:0]), .ser_in(ser_in), .parallel_out(pout8), .ser_out(so[0]),
        .busy(bsy[0]), .done(dn[0])
    );

    univ_shift_reg #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .op(op), .start(start), .shift_cnt(cnt[1:0]),
        .parallel_in(pin[1:0]), .ser_in(ser_in), .parallel_out(pout2), .ser_out(so[1]),
        .busy(bsy[1]), .done(dn[1])
    );

    univ_shift_reg #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .op(op), .start(start), .shift_cnt(cnt[5:0]),
        .parallel_in(pin), .ser_in(ser_in), .parallel_out(pout32), .ser_out(so[2]),
        .busy(bsy[2]), .done(dn[2])
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model, one lane per instance.
    int unsigned     lw[3]  = '{8, 2, 32};
    int unsigned     lcw[3] = '{4, 2, 6};
    longint unsigned m_val[3];
    longint unsigned m_ld[3];
    bit              m_so[3];
    int              m_steps[3];  // sequenced steps still to execute
    bit              m_done[3];   // a done cycle is still owed after the steps
    int              m_op[3];

    function automatic void m_reset();
        for (int l = 0; l < 3; l++) begin
            m_val[l]   = 0;
            m_ld[l]    = 0;
            m_so[l]    = 0;
            m_steps[l] = 0;
            m_done[l]  = 0;
            m_op[l]    = 0;
        end
    endfunction

    function automatic void m_apply(int l, int o, longint unsigned ldv, bit s);
        longint unsigned mask;
        longint unsigned top;
        bit              msb;
        bit              lsb;
        mask = (64'd1 << lw[l]) - 64'd1;
        top  = 64'd1 << (lw[l] - 1);
        msb  = ((m_val[l] >> (lw[l] - 1)) & 64'd1) != 0;
        lsb  = (m_val[l] & 64'd1) != 0;
        case (o)
            1: m_val[l] = ldv & mask;
            2: begin m_so[l] = msb; m_val[l] = (m_val[l] * 2 + longint'(s)) & mask; end
            3: begin m_so[l] = lsb; m_val[l] = m_val[l] / 2 + (s ? top : 64'd0); end
            4: begin m_so[l] = msb; m_val[l] = (m_val[l] * 2 + longint'(msb)) & mask; end
            5: begin m_so[l] = lsb; m_val[l] = m_val[l] / 2 + (lsb ? top : 64'd0); end
            6: begin m_so[l] = lsb; m_val[l] = m_val[l] / 2 + (msb ? top : 64'd0); end
            7: m_val[l] = 0;
            default: ;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void m_edge();
        for (int l = 0; l < 3; l++) begin
            if (m_steps[l] == 0 && !m_done[l]) begin
                if (start) begin
                    int c;
                    c          = int'(cnt) & ((1 << lcw[l]) - 1);
                    m_op[l]    = int'(op);
                    m_ld[l]    = longint'(pin);
                    m_steps[l] = (c == 0 || op == 3'd0) ? 0 : c;
                    m_done[l]  = 1;
                end else begin
                    m_apply(l, int'(op), longint'(pin), ser_in);
                end
            end else if (m_steps[l] > 0) begin
                m_apply(l, m_op[l], m_ld[l], ser_in);
                m_steps[l]--;
            end else begin
                m_done[l] = 0;
            end
        end
    endfunction

    function automatic logic [63:0] dut_val(int l);
        case (l)
            0:       return 64'(pout8);
            1:       return 64'(pout2);
            default: return 64'(pout32);
        endcase
    endfunction

    task automatic check_all(input string tag);
        for (int l = 0; l < 3; l++) begin
            check_val($sformatf("%s.w%0d.val", tag, lw[l]), dut_val(l), m_val[l]);
            check_val($sformatf("%s.w%0d.ser", tag, lw[l]), 64'(so[l]), 64'(m_so[l]));
            check_val($sformatf("%s.w%0d.busy", tag, lw[l]), 64'(bsy[l]),
                      64'(m_steps[l] > 0 || m_done[l]));
            check_val($sformatf("%s.w%0d.done", tag, lw[l]), 64'(dn[l]),
                      64'(m_steps[l] == 0 && m_done[l]));
        end
    endtask

    task automatic drive(input int o, input bit st, input int c, input logic [31:0] p,
                         input bit s);
        op     = 3'(o);
        start  = st;
        cnt    = 6'(c);
        pin    = p;
        ser_in = s;
    endtask

    task automatic tick(input string tag);
        m_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 32'h0, 1'b0);
            tick(tag);
        end
    endtask

    // Pulse the asynchronous reset between clock edges.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all(tag);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int busy_cycles;
        int done_pulses;
        logic [7:0] bits;

        drive(0, 0, 0, 32'h0, 1'b0);
        rst_n = 1'b1;
        m_reset();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Direct single-step ops.
        drive(1, 0, 0, 32'h96, 0); tick("load");
        check_val("load96", 64'(pout8), 64'h96);
        drive(2, 0, 0, 32'h0, 1); tick("shl");
        check_val("shl_val", 64'(pout8), 64'h2D);
        check_val("shl_ser", 64'(so[0]), 64'h1);
        drive(3, 0, 0, 32'h0, 0); tick("shr");
        check_val("shr_val", 64'(pout8), 64'h16);
        check_val("shr_ser", 64'(so[0]), 64'h1);
        drive(1, 0, 0, 32'h80, 0); tick("load80");
        drive(6, 0, 0, 32'h0, 0); tick("asr");
        check_val("asr_val", 64'(pout8), 64'hC0);
        drive(7, 0, 0, 32'h0, 0); tick("clear");
        check_val("clear_val", 64'(pout8), 64'h0);

        // Auto rotate; start/op noise while busy and during done must be ignored.
        drive(1, 0, 0, 32'h81, 0); tick("load81");
        drive(5, 1, 4, 32'h0, 0); tick("ror_start");
        check_val("ror_start_hold", 64'(pout8), 64'h81);
        busy_cycles = int'(bsy[0]);
        done_pulses = int'(dn[0]);
        for (int i = 0; i < 5; i++) begin
            drive(int'($urandom_range(0, 7)), 1, 2, $urandom, 1'($urandom));
            tick("ror_run");
            if (i == 3) check_val("ror_val", 64'(pout8), 64'h18);
            busy_cycles += int'(bsy[0]);
            done_pulses += int'(dn[0]);
        end
        check_val("ror_busy_cycles", 64'(busy_cycles), 64'd5);
        check_val("ror_done_pulses", 64'(done_pulses), 64'd1);
        idle(6, "ror_tail");

        // Deserialise eight bits MSB first.
        drive(7, 0, 0, 32'h0, 0); tick("des_clear");
        drive(2, 1, 8, 32'h0, 0); tick("des_start");
        bits = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            drive(int'($urandom_range(0, 7)), 0, 0, $urandom, bits[7 - i]);
            tick("des_run");
        end
        check_val("des_val", 64'(pout8), 64'hB2);
        check_val("des_done", 64'(dn[0]), 64'h1);
        idle(3, "des_tail");

        // Zero count: done right after start, register unchanged.
        drive(1, 0, 0, 32'h5A, 0); tick("cnt0_load");
        drive(2, 1, 0, 32'h0, 1); tick("cnt0_start");
        check_val("cnt0_done", 64'(dn[0]), 64'h1);
        check_val("cnt0_val", 64'(pout8), 64'h5A);
        idle(2, "cnt0_tail");

        // Count above WIDTH wraps the rotate.
        drive(1, 0, 0, 32'h01, 0); tick("cnt9_load");
        drive(4, 1, 9, 32'h0, 0); tick("cnt9_start");
        idle(9, "cnt9_run");
        check_val("cnt9_val", 64'(pout8), 64'h02);
        check_val("cnt9_done", 64'(dn[0]), 64'h1);
        idle(2, "cnt9_tail");

        // start during done is dropped, then accepted the next cycle.
        drive(1, 0, 0, 32'h03, 0); tick("sd_load");
        drive(2, 1, 1, 32'h0, 0); tick("sd_start");
        drive(0, 0, 0, 32'h0, 0); tick("sd_step");
        drive(2, 1, 1, 32'h0, 0); tick("sd_during_done");
        check_val("sd_ignored", 64'(bsy[0]), 64'h0);
        tick("sd_accept");
        check_val("sd_accepted", 64'(bsy[0]), 64'h1);
        idle(4, "sd_tail");

        // WIDTH=32 full rotate leaves the value unchanged.
        drive(1, 0, 0, 32'hC3A5_0F81, 0); tick("w32_load");
        drive(4, 1, 32, 32'h0, 0); tick("w32_start");
        idle(32, "w32_run");
        check_val("w32_rol_val", 64'(pout32), 64'hC3A5_0F81);
        check_val("w32_rol_done", 64'(dn[2]), 64'h1);
        idle(2, "w32_tail");

        // WIDTH=2 full rotate.
        drive(1, 0, 0, 32'h2, 0); tick("w2_load");
        drive(4, 1, 2, 32'h0, 0); tick("w2_start");
        idle(2, "w2_run");
        check_val("w2_rol_val", 64'(pout2), 64'h2);
        check_val("w2_rol_done", 64'(dn[1]), 64'h1);
        idle(2, "w2_tail");

        // ASR with MSB set fills with ones.
        drive(1, 0, 0, 32'h8000_0002, 0); tick("asr_load");
        for (int i = 0; i < 31; i++) begin
            drive(6, 0, 0, 32'h0, 0);
            tick("asr_fill");
        end
        check_val("w32_asr_fill", 64'(pout32), 64'hFFFF_FFFF);
        check_val("w2_asr_fill", 64'(pout2), 64'h3);

        // Reset mid-sequence aborts without a done pulse.
        drive(1, 0, 0, 32'hA5, 0); tick("rm_load");
        drive(4, 1, 7, 32'h0, 0); tick("rm_start");
        idle(2, "rm_run");
        async_reset("rm_reset");
        check_val("rm_val", 64'(pout8), 64'h0);
        check_val("rm_busy", 64'(bsy[0]), 64'h0);
        idle(3, "rm_tail");

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset("rnd_reset");
            end
            drive(int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 40)), $urandom, 1'($urandom));
            tick("rnd");
        end
        idle(40, "rnd_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
